// File: rtl/grey_wptr_ctrl_if.sv
// Producer / RAM-write / synchronizer-facing signal bundle of the FIFO write-pointer controller.
// The "slave" side is the controller; the "master" side is the producer and read-pointer source.
interface grey_wptr_ctrl_if #(
  parameter int DEPTH_LOG2 = 2
);
  localparam int P = DEPTH_LOG2 + 1;

  logic                  push_valid_i;
  logic                  push_ready_o;
  logic                  wr_en_o;
  logic [DEPTH_LOG2-1:0] wr_addr_o;
  logic [P-1:0]          wptr_grey_o;
  logic [P-1:0]          rptr_grey_i;
  logic                  full_o;
  logic [P-1:0]          level_o;
  logic                  overflow_o;
  logic                  ptr_err_o;

  modport master (
    output push_valid_i,
    output rptr_grey_i,
    input  push_ready_o,
    input  wr_en_o,
    input  wr_addr_o,
    input  wptr_grey_o,
    input  full_o,
    input  level_o,
    input  overflow_o,
    input  ptr_err_o
  );

  modport slave (
    input  push_valid_i,
    input  rptr_grey_i,
    output push_ready_o,
    output wr_en_o,
    output wr_addr_o,
    output wptr_grey_o,
    output full_o,
    output level_o,
    output overflow_o,
    output ptr_err_o
  );
endinterface

// File: rtl/grey_wptr_ctrl.sv
// Write-domain pointer controller for a CDC FIFO: binary/Grey write pointer, full/level
// derived from the synchronized Grey read pointer, overflow pulse and sticky overtake flag.
module grey_wptr_ctrl #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  grey_wptr_ctrl_if.slave bus
);
  localparam int P = DEPTH_LOG2 + 1;
  localparam logic [P-1:0] DEPTH = P'(2 ** DEPTH_LOG2);

  // Pointer widths outside 2..4 are not supported by the Grey decoder.
  generate
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 3) begin : g_illegal_depth
      PanicModule u_panic ();
    end
  endgenerate

  function automatic logic [P-1:0] grey_decode(input logic [P-1:0] grey);
    logic [P-1:0] bin;
    bin[P-1] = grey[P-1];
    for (int i = P - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ grey[i];
    end
    return bin;
  endfunction

  logic [P-1:0] wbin_q;
  logic [P-1:0] wgrey_q;
  logic [P-1:0] rbin_q;
  logic         err_q;

  logic [P-1:0] rbin_now;
  logic [P-1:0] wbin_next;
  logic [P-1:0] wgrey_next;
  logic [P-1:0] level;
  logic [P-1:0] lead;
  logic         full;
  logic         ready;
  logic         accept;

  assign rbin_now  = grey_decode(bus.rptr_grey_i);
  assign wbin_next = wbin_q + P'(1);

  genvar gi;
  generate
    for (gi = 0; gi < P - 1; gi++) begin : g_grey_enc
      assign wgrey_next[gi] = wbin_next[gi] ^ wbin_next[gi+1];
    end
  endgenerate
  assign wgrey_next[P-1] = wbin_next[P-1];

  // Level uses the registered read pointer, so a read only frees space one cycle late.
  assign level  = wbin_q - rbin_q;
  assign full   = (level == DEPTH);
  assign ready  = !full && !err_q;
  assign accept = bus.push_valid_i && ready;

  // Overtake check looks at the fresh read pointer so the error lands on the next edge.
  assign lead = wbin_q - rbin_now;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbin_q  <= '0;
      wgrey_q <= '0;
      rbin_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      rbin_q <= rbin_now;
      if (accept) begin
        wbin_q  <= wbin_next;
        wgrey_q <= wgrey_next;
      end
      if (lead > DEPTH) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.push_ready_o = ready;
  assign bus.wr_en_o      = accept;
  assign bus.wr_addr_o    = wbin_q[DEPTH_LOG2-1:0];
  assign bus.wptr_grey_o  = wgrey_q;
  assign bus.full_o       = full;
  assign bus.level_o      = level;
  assign bus.overflow_o   = bus.push_valid_i && full && !err_q;
  assign bus.ptr_err_o    = err_q;
endmodule

// Empty module elaborated only for unsupported pointer widths.
module PanicModule;
endmodule

// File: tb/tb_grey_wptr_ctrl.sv
// Directed bench for grey_wptr_ctrl (DEPTH_LOG2=2): reset, fill, overflow, drain, wrap,
// pointer-overtake error and asynchronous mid-push reset, checked against a reference model.
module tb_grey_wptr_ctrl;
  localparam int DL = 2;
  localparam int P  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grey_wptr_ctrl_if #(.DEPTH_LOG2(DL)) bus ();

  grey_wptr_ctrl #(.DEPTH_LOG2(DL)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic          ready;
    logic          wr_en;
    logic          full;
    logic          ovf;
    logic          err;
    logic [P-1:0]  level;
    logic [P-1:0]  wgrey;
    logic [DL-1:0] waddr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [P-1:0] m_wbin;
  logic [P-1:0] m_rbin;
  logic         m_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P-1:0] g2b(input logic [P-1:0] g);
    return g ^ (g >> 1) ^ (g >> 2);
  endfunction

  function automatic logic [P-1:0] b2g(input logic [P-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wbin = '0;
    m_rbin = '0;
    m_err  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".ready"}, 8'(bus.push_ready_o), 8'h1);
    chk({tag, ".full"},  8'(bus.full_o),       8'h0);
    chk({tag, ".level"}, 8'(bus.level_o),      8'h0);
    chk({tag, ".wgrey"}, 8'(bus.wptr_grey_o),  8'h0);
    chk({tag, ".waddr"}, 8'(bus.wr_addr_o),    8'h0);
    chk({tag, ".ovf"},   8'(bus.overflow_o),   8'h0);
    chk({tag, ".err"},   8'(bus.ptr_err_o),    8'h0);
  endtask

  // One cycle: drive at negedge, sample 1 ns later, then advance the model past the posedge.
  task automatic step(input logic v, input logic [P-1:0] rg, input string tag);
    exp_t         e;
    exp_t         got;
    logic [P-1:0] lvl;
    @(negedge clk);
    bus.push_valid_i = v;
    bus.rptr_grey_i  = rg;
    #1;
    lvl     = m_wbin - m_rbin;
    e.level = lvl;
    e.full  = (lvl == 3'd4);
    e.err   = m_err;
    e.ready = !e.full && !m_err;
    e.wr_en = v && e.ready;
    e.ovf   = v && e.full && !m_err;
    e.wgrey = b2g(m_wbin);
    e.waddr = m_wbin[DL-1:0];
    sb.push_back(e);

    got = sb.pop_front();
    chk({tag, ".ready"}, 8'(bus.push_ready_o), 8'(got.ready));
    chk({tag, ".wr_en"}, 8'(bus.wr_en_o),      8'(got.wr_en));
    chk({tag, ".full"},  8'(bus.full_o),       8'(got.full));
    chk({tag, ".ovf"},   8'(bus.overflow_o),   8'(got.ovf));
    chk({tag, ".err"},   8'(bus.ptr_err_o),    8'(got.err));
    chk({tag, ".level"}, 8'(bus.level_o),      8'(got.level));
    chk({tag, ".wgrey"}, 8'(bus.wptr_grey_o),  8'(got.wgrey));
    chk({tag, ".waddr"}, 8'(bus.wr_addr_o),    8'(got.waddr));
    $display("t=%0t %s valid=%0b rptr=%03b ready=%0b wr_en=%0b addr=%0d wgrey=%03b level=%0d full=%0b ovf=%0b err=%0b",
             $time, tag, v, rg, bus.push_ready_o, bus.wr_en_o, bus.wr_addr_o, bus.wptr_grey_o,
             bus.level_o, bus.full_o, bus.overflow_o, bus.ptr_err_o);

    if (P'(m_wbin - g2b(rg)) > 3'd4) m_err = 1'b1;
    if (e.wr_en) m_wbin = m_wbin + 3'd1;
    m_rbin = g2b(rg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P-1:0] g_seq [5];
    g_seq[0] = 3'b000;
    g_seq[1] = 3'b001;
    g_seq[2] = 3'b011;
    g_seq[3] = 3'b010;
    g_seq[4] = 3'b110;

    bus.push_valid_i = 1'b0;
    bus.rptr_grey_i  = '0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check_reset("reset_hold");
    rst_n = 1'b1;
    step(1'b0, 3'b000, "reset");

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'b000, "fill");
      chk("fill.grey_seq", 8'(bus.wptr_grey_o), 8'(g_seq[i]));
      chk("fill.addr_seq", 8'(bus.wr_addr_o),   8'(i[1:0]));
    end

    step(1'b1, 3'b000, "overflow");
    chk("overflow.pulse", 8'(bus.overflow_o),  8'h1);
    chk("overflow.grey",  8'(bus.wptr_grey_o), 8'(g_seq[4]));
    chk("overflow.level", 8'(bus.level_o),     8'h4);
    step(1'b0, 3'b000, "idle_full");

    step(1'b0, 3'b001, "drain");
    step(1'b1, 3'b001, "drain_push");
    chk("drain.level", 8'(bus.level_o),      8'h3);
    chk("drain.ready", 8'(bus.push_ready_o), 8'h1);
    step(1'b0, 3'b001, "after_push");
    chk("after_push.grey",  8'(bus.wptr_grey_o), 8'h7);
    chk("after_push.level", 8'(bus.level_o),     8'h4);

    step(1'b1, 3'b011, "wrap_a");
    step(1'b1, 3'b010, "wrap_b");
    step(1'b1, 3'b010, "wrap_c");
    step(1'b1, 3'b010, "wrap_d");
    step(1'b1, 3'b101, "wrap_jump");
    step(1'b1, 3'b101, "wrap_push");
    chk("wrap.grey_before", 8'(bus.wptr_grey_o), 8'h4);
    step(1'b0, 3'b101, "wrap_done");
    chk("wrap.grey_after", 8'(bus.wptr_grey_o), 8'h0);
    chk("wrap.level",      8'(bus.level_o),     8'h2);

    step(1'b1, 3'b101, "to_two_a");
    step(1'b1, 3'b101, "to_two_b");
    step(1'b0, 3'b110, "err_trig");
    step(1'b1, 3'b110, "err_set");
    chk("err.flag",  8'(bus.ptr_err_o),    8'h1);
    chk("err.ready", 8'(bus.push_ready_o), 8'h0);
    step(1'b1, 3'b101, "err_a");
    step(1'b1, 3'b101, "err_full");
    chk("err.full_no_ovf", 8'(bus.overflow_o), 8'h0);
    step(1'b1, 3'b000, "err_b");
    step(1'b1, 3'b000, "err_c");
    chk("err.frozen", 8'(bus.wptr_grey_o), 8'h3);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("err_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.push_valid_i = 1'b0;
    bus.rptr_grey_i  = '0;

    step(1'b0, 3'b000, "post_reset");
    step(1'b1, 3'b000, "push_a");
    @(negedge clk);
    bus.push_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_push");
    model_reset();
    @(posedge clk);
    #1;
    chk("mid_push.dropped", 8'(bus.wptr_grey_o), 8'h0);
    @(negedge clk);
    bus.push_valid_i = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 3'b000, "after_reset");
    step(1'b1, 3'b000, "restart_push");
    step(1'b0, 3'b000, "restart_idle");
    chk("restart.grey", 8'(bus.wptr_grey_o), 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/grey_wptr_ctrl.md
# grey_wptr_ctrl

Write-side pointer controller for a clock-domain-crossing FIFO. It owns the binary and Grey-coded write pointer and accepts pushes under a valid/ready handshake. It decodes the already-synchronized Grey read pointer with `GreyDecode` and derives full, fill level, overflow and pointer-consistency flags. It sits in the write clock domain, between the producer, the FIFO RAM write port and the pointer synchronizer toward the read domain.

## Interface
- `DEPTH_LOG2`, default 2: FIFO depth is `2**DEPTH_LOG2`.
  - Pointer width `P = DEPTH_LOG2+1`.
  - Legal values are 1..3, so `P` is 2..4, the range supported by `GreyDecode`. Any other value instantiates `PanicModule`.
- `clk_i`  in  1  write-domain clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `push_valid_i`  in  1  producer offers a word.
- `push_ready_o`  out  1  controller can accept a word.
- `wr_en_o`  out  1  RAM write strobe, equal to `push_valid_i & push_ready_o`.
- `wr_addr_o`  out  DEPTH_LOG2  RAM write address, the low bits of the binary write pointer.
- `wptr_grey_o`  out  P  registered Grey write pointer, sent to the read-domain synchronizer.
- `rptr_grey_i`  in  P  Grey read pointer, already synchronized into `clk_i`.
- `full_o`  out  1  FIFO holds `2**DEPTH_LOG2` words.
- `level_o`  out  P  fill count, range 0..`2**DEPTH_LOG2`.
- `overflow_o`  out  1  one-cycle pulse when a push is attempted while the FIFO is full.
- `ptr_err_o`  out  1  sticky flag: the read pointer overtook the write pointer.

## Operation
- State registers:
  - `wbin_q` (P bits)
  - `wgrey_q` (P bits)
  - `rbin_q` (P bits): decoded read pointer
  - `err_q`
- Every cycle, `rbin_q <= GreyDecode(rptr_grey_i)`. This register breaks the combinational path from the synchronizer.
- `level = (wbin_q - rbin_q) mod 2**P`.
  - Computed in P-bit unsigned arithmetic; wrap-around is intentional.
- `full_o = (level == 2**DEPTH_LOG2)`.
- `push_ready_o = !full_o && !err_q`.
- Accepted push (`wr_en_o=1`):
  - `wbin_q <= wbin_q+1`, wrapping mod `2**P`.
  - `wgrey_q <= next ^ (next>>1)`, where `next = wbin_q+1`.
- `wptr_grey_o = wgrey_q`.
  - Driven directly from the flop, never from combinational logic.
  - Exactly one bit changes per accepted push.
- `overflow_o = push_valid_i && full_o && !err_q`.
  - Combinational pulse.
  - The pointer is not changed.
- Consistency check:
  - If `(wbin_q - GreyDecode(rptr_grey_i)) mod 2**P > 2**DEPTH_LOG2`, set `err_q` at the next edge.
  - `err_q` is cleared only by reset.
  - While `err_q=1`: `push_ready_o=0`, `wr_en_o=0`, `overflow_o=0`, and the write pointer is frozen.
- A read pointer that advances by several positions in one sample is legal; only overtaking the write pointer is an error.
- A push and a read-pointer update in the same cycle are both applied. The new level reflects both changes one cycle later.

## Timing
- Reset values:
  - `wbin_q`, `wgrey_q`, `rbin_q` = 0; `err_q` = 0.
  - Outputs: `push_ready_o=1`, `full_o=0`, `level_o=0`, `wptr_grey_o=0`, `wr_addr_o=0`, `overflow_o=0`, `ptr_err_o=0`.
- Reset asserted mid-push: all state clears immediately and asynchronously. The in-flight push is dropped.
- Push latency:
  - The word is accepted on the edge where `push_valid_i && push_ready_o`.
  - `wr_addr_o` shows the slot written in that same cycle.
  - `wptr_grey_o`, `level_o` and `full_o` update on that edge.
- Read-side latency:
  - A change on `rptr_grey_i` reaches `level_o`, `full_o` and `push_ready_o` one cycle later.
  - This is conservative: the FIFO can appear full for one extra cycle, but never falsely not-full.
- Push on the edge that makes the FIFO full: accepted. `push_ready_o` drops in the following cycle.
- Pointer wrap: `wbin_q` goes `2**P-1 -> 0` and `wgrey_q` goes `100..0 -> 000..0`, a single-bit change.

## Test plan
All scenarios use `DEPTH_LOG2=2` (P=3, depth 4).
- **Reset:** release `rst_ni` with `rptr_grey_i=000` -> `push_ready_o=1`, `level_o=0`, `full_o=0`, `wptr_grey_o=000`, `ptr_err_o=0`.
- **Fill:** four back-to-back pushes, `rptr_grey_i=000` -> `wr_addr_o` 0,1,2,3; `wptr_grey_o` 001,011,010,110; then `level_o=100`, `full_o=1`, `push_ready_o=0`.
- **Overflow:** push while full -> `overflow_o=1` for one cycle, `wr_en_o=0`, `wptr_grey_o` stays 110.
- **Drain one:** `rptr_grey_i` 000->001 -> one cycle later `level_o=011`, `full_o=0`, `push_ready_o=1`. A push in that cycle gives `wptr_grey_o=111`, `level_o=100`.
- **Wrap:** continue pushes and reads until `wbin_q` 7->0 -> `wptr_grey_o` 100->000, and `level_o` stays correct across the wrap (e.g. `wbin=0`, `rbin=6` gives `level=2`).
- **Error and mid-push reset:**
  - With `wbin_q=2`, drive `rptr_grey_i=110` (binary 4) -> `ptr_err_o=1` next cycle.
  - Pushes are then refused permanently.
  - Asserting `rst_ni` low mid-push clears every output to its reset value asynchronously.
